// File: rtl/regfile_immgen_if.sv
// Decode-slice bus: register file ports plus immediate generator ports.
// master drives addresses/data/instr; slave (the datapath) returns reads and imm.
interface regfile_immgen_if;
    logic        we3;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] instr;
    logic [2:0]  imm_src;
    logic [31:0] imm_ext;

    modport master (
        output we3, a1, a2, a3, wd3, instr, imm_src,
        input  rd1, rd2, imm_ext
    );

    modport slave (
        input  we3, a1, a2, a3, wd3, instr, imm_src,
        output rd1, rd2, imm_ext
    );
endinterface

// File: rtl/regfile_immgen.sv
// RV32I decode datapath slice: 32x32 register file (2 comb reads, 1 sync write)
// and immediate generator. Ports: clk, rst (async high), bus (slave modport).
module regfile_immgen (
    input  logic              clk,
    input  logic              rst,
    regfile_immgen_if.slave   bus
);
    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    logic [XLEN-1:0] regs_q [NREGS];
    logic            wr_en;

    // x0 is never written, so it stays at its reset value of zero.
    assign wr_en = bus.we3 && (bus.a3 != 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[bus.a3] <= bus.wd3;
        end
    end

    assign bus.rd1 = (bus.a1 == 5'd0) ? '0 : regs_q[bus.a1];
    assign bus.rd2 = (bus.a2 == 5'd0) ? '0 : regs_q[bus.a2];

    logic [31:0] i;
    logic [31:0] imm;
    logic        unused_opcode;

    assign i = bus.instr;
    // Opcode bits carry no immediate content.
    assign unused_opcode = ^i[6:0];

    always_comb begin
        imm = '0;
        unique case (bus.imm_src)
            3'b000: imm = {{20{i[31]}}, i[31:20]};
            3'b001: imm = {{20{i[31]}}, i[31:25], i[11:7]};
            3'b010: imm = {{19{i[31]}}, i[31], i[7], i[30:25],
                           i[11:8], 1'b0};
            3'b011: imm = {i[31:12], 12'b0};
            3'b100: imm = {{11{i[31]}}, i[31], i[19:12], i[20],
                           i[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    assign bus.imm_ext = imm;
endmodule

// File: tb/tb_regfile_immgen.sv
// Self-checking bench for regfile_immgen: directed vectors with literal
// expectations plus a per-cycle comparison against an arithmetic model.
module tb_regfile_immgen;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    bit   cmp_en;

    regfile_immgen_if bus ();

    regfile_immgen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] m_regs [32];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 32; k++) m_regs[k] = 32'h0;
        end else if (bus.we3 && bus.a3 != 5'd0) begin
            m_regs[bus.a3] = bus.wd3;
        end
    end

    function automatic logic [31:0] ref_imm(logic [31:0] ins,
                                            logic [2:0] sel);
        int v;
        int s31;
        s31 = ins[31] ? -1 : 0;
        v = 0;
        case (sel)
            3'd0: v = $signed(ins) >>> 20;
            3'd1: v = s31 * 2048 + int'(ins[30:25]) * 32
                      + int'(ins[11:7]);
            3'd2: v = s31 * 4096 + int'(ins[7]) * 2048
                      + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
            3'd3: v = ins & 32'hFFFFF000;
            3'd4: v = s31 * (1 << 20) + int'(ins[19:12]) * 4096
                      + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
            default: v = 0;
        endcase
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_rd1", bus.rd1, m_regs[bus.a1]);
            check("model_rd2", bus.rd2, m_regs[bus.a2]);
            check("model_imm", bus.imm_ext,
                  ref_imm(bus.instr, bus.imm_src));
        end
    end

    task automatic wr(logic [4:0] a, logic [31:0] d);
        bus.we3 = 1'b1;
        bus.a3  = a;
        bus.wd3 = d;
        @(posedge clk);
        #2 bus.we3 = 1'b0;
    endtask

    task automatic imm_chk(string name, logic [31:0] ins,
                           logic [2:0] sel, logic [31:0] exp);
        bus.instr   = ins;
        bus.imm_src = sel;
        #1 check(name, bus.imm_ext, exp);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cmp_en = 1'b0;
        rst = 1'b1;
        bus.we3 = 1'b1;
        bus.a3 = 5'd1;
        bus.wd3 = 32'd100;
        bus.a1 = 5'd1;
        bus.a2 = 5'd0;
        bus.instr = 32'h0;
        bus.imm_src = 3'd0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        bus.we3 = 1'b0;
        cmp_en = 1'b1;
        #1 check("reset_blocks_write", bus.rd1, 32'h0);

        wr(5'd1, 32'd100);
        bus.a1 = 5'd1;
        bus.a2 = 5'd0;
        #1 check("x1_write", bus.rd1, 32'd100);
        check("x0_read", bus.rd2, 32'h0);

        wr(5'd0, 32'hDEADBEEF);
        bus.a1 = 5'd0;
        #1 check("x0_discard", bus.rd1, 32'h0);

        wr(5'd31, 32'hFFFFFFFF);
        bus.a1 = 5'd31;
        bus.a2 = 5'd31;
        #1 check("x31_p1", bus.rd1, 32'hFFFFFFFF);
        check("x31_p2", bus.rd2, 32'hFFFFFFFF);

        bus.we3 = 1'b1;
        bus.a3 = 5'd6;
        bus.wd3 = 32'd55;
        bus.a1 = 5'd6;
        #1 check("no_bypass_before", bus.rd1, 32'h0);
        @(posedge clk);
        #2 bus.we3 = 1'b0;
        check("after_edge", bus.rd1, 32'd55);

        for (int k = 0; k < 8; k++) begin
            wr(5'(k * 3 + 2), $urandom);
            bus.a1 = 5'(k * 3 + 2);
            bus.a2 = 5'(k + 1);
        end

        wr(5'd5, 32'd7);
        bus.a1 = 5'd5;
        #1 check("x5_write", bus.rd1, 32'd7);
        rst = 1'b1;
        #1 check("async_rst", bus.rd1, 32'h0);
        bus.a1 = 5'd31;
        #1 check("async_rst_x31", bus.rd1, 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;

        imm_chk("imm_I_pos", 32'h00500093, 3'd0, 32'd5);
        imm_chk("imm_I_neg", 32'hFFF00093, 3'd0, 32'hFFFFFFFF);
        imm_chk("imm_S", 32'hFE20AE23, 3'd1, 32'hFFFFFFFC);
        imm_chk("imm_U", 32'h123450B7, 3'd3, 32'h12345000);
        imm_chk("imm_B", 32'hFE000CE3, 3'd2, 32'hFFFFFFF8);
        imm_chk("imm_J", 32'h0080006F, 3'd4, 32'h00000008);
        imm_chk("imm_111", 32'hFE000CE3, 3'd7, 32'h0);
        imm_chk("imm_legacy1", 32'hFE20AE23, {2'b00, 1'b1}, 32'hFFFFFFFC);
        check("model_pin_B", ref_imm(32'hFE000CE3, 3'd2), 32'hFFFFFFF8);
        check("model_pin_J", ref_imm(32'h0080006F, 3'd4), 32'h00000008);

        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #2;
            bus.instr = $urandom;
            bus.imm_src = 3'(k % 8);
            bus.we3 = 1'b1;
            bus.a3 = 5'($urandom_range(0, 31));
            bus.wd3 = $urandom;
            bus.a1 = 5'($urandom_range(0, 31));
            bus.a2 = bus.a3;
        end
        @(posedge clk);
        #2 bus.we3 = 1'b0;
        @(negedge clk);
        @(posedge clk);
        cmp_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
